fifo_rblock: RTL and testbench

Read-side control block of the asynchronous FIFO. It is the counterpart of the write-pointer/full-flag block. It synchronizes the Gray write pointer into the read clock domain and keeps the binary/Gray read pointer. It drives the memory read address, generates a registered empty flag and an occupancy count, and presents data through a one-deep valid/ready output register. The memory read path is combinational from raddr.

---
 rtl/fifo_rblock.sv | 74 +++++++
 tb/tb_fifo_rblock.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rblock.sv
// rtl/fifo_rblock.sv - async FIFO read-side control: wptr sync, read pointer, empty flag, level, output register
module fifo_rblock #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 8
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   wptr_gray,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rready,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr,
  output logic              rempty,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W:0]   rlevel
);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] rq1;
  logic [ADDR_W:0] rq2;
  logic [ADDR_W:0] rbinnext;
  logic [ADDR_W:0] rgraynext;
  logic            load;

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b = g;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A word leaves memory only when the output register is free or being drained this cycle.
  always_comb begin
    load      = !rempty && (!rvalid || rready);
    rbinnext  = rbin + {{ADDR_W{1'b0}}, load};
    rgraynext = rbinnext ^ (rbinnext >> 1);
  end

  assign raddr = rbin[ADDR_W-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1    <= '0;
      rq2    <= '0;
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      rlevel <= '0;
    end else begin
      rq1    <= wptr_gray;
      rq2    <= rq1;
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      rempty <= (rgraynext == rq2);
      rlevel <= gray2bin(rq2) - rbinnext;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else if (load) begin
      rdata  <= mem_rdata;
      rvalid <= 1'b1;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rblock.sv
// tb/tb_fifo_rblock.sv - directed-vector bench for fifo_rblock at depth 8
module tb_fifo_rblock;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [3:0] wptr_gray;
  logic [7:0] mem_rdata;
  logic       rready;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic [7:0] rdata;
  logic       rvalid;
  logic [3:0] rlevel;

  logic [7:0] mem [8];
  int         n_vec = 0;
  int         n_err = 0;

  fifo_rblock #(.ADDR_W(3), .DATA_W(8)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .wptr_gray (wptr_gray),
    .mem_rdata (mem_rdata),
    .rready    (rready),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rlevel    (rlevel)
  );

  always #5 rclk = ~rclk;
  assign mem_rdata = mem[raddr];

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst      = 1'b1;
    wptr_gray = 4'b0000;
    rready    = 1'b0;
    tick();
    tick();
    rrst = 1'b0;
    tick();
    tick();
  endtask

  // Publish write pointer wbin, then read n words starting from read pointer st.
  task automatic burst(input logic [3:0] wbin, input logic [7:0] base, input int n, input logic [3:0] st);
    logic [3:0] prev;
    wptr_gray = bin2gray(wbin);
    rready    = 1'b1;
    tick();
    tick();
    check("burst_empty_e2", rempty, 1);
    tick();
    check("burst_empty_e3", rempty, 0);
    check("burst_level_e3", rlevel, 4'(wbin - st));
    for (int i = 0; i < n; i++) begin
      prev = rptr;
      tick();
      check("burst_valid", rvalid, 1);
      check("burst_data", rdata, 8'(base + 8'(i)));
      check("burst_rptr", rptr, bin2gray(4'(st + 4'(i) + 4'd1)));
      check("burst_gray_step", $countones(rptr ^ prev), 1);
    end
    check("burst_end_empty", rempty, 1);
    check("burst_end_raddr", raddr, 3'(st + 4'(n)));
    check("burst_end_level", rlevel, 0);
    tick();
    check("burst_valid_fall", rvalid, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // reset state
    rrst      = 1'b1;
    wptr_gray = 4'b0000;
    rready    = 1'b0;
    tick();
    tick();
    check("rst_empty", rempty, 1);
    check("rst_valid", rvalid, 0);
    check("rst_rptr", rptr, 0);
    check("rst_raddr", raddr, 0);
    check("rst_level", rlevel, 0);
    check("rst_data", rdata, 0);
    rrst = 1'b0;
    tick();
    check("idle_empty", rempty, 1);

    // single word, held under backpressure
    mem[0]    = 8'hA5;
    wptr_gray = 4'b0001;
    tick();
    tick();
    check("single_empty_e2", rempty, 1);
    tick();
    check("single_empty_e3", rempty, 0);
    check("single_valid_e3", rvalid, 0);
    check("single_level_e3", rlevel, 1);
    tick();
    check("single_valid_e4", rvalid, 1);
    check("single_data_e4", rdata, 8'hA5);
    check("single_raddr_e4", raddr, 1);
    check("single_rptr_e4", rptr, 4'b0001);
    check("single_empty_e4", rempty, 1);
    check("single_level_e4", rlevel, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("single_hold_valid", rvalid, 1);
      check("single_hold_data", rdata, 8'hA5);
      check("single_hold_raddr", raddr, 1);
    end

    // streaming a full memory
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    burst(4'd8, 8'h10, 8, 4'd0);
    check("stream_rptr", rptr, 4'b1100);

    // backpressure with 4 words available, read pointer at 8
    for (int i = 0; i < 4; i++) mem[i] = 8'h20 + 8'(i);
    rready    = 1'b0;
    wptr_gray = bin2gray(4'd12);
    for (int i = 0; i < 4; i++) tick();
    check("bp_valid", rvalid, 1);
    check("bp_data", rdata, 8'h20);
    check("bp_level", rlevel, 3);
    check("bp_raddr", raddr, 1);
    for (int i = 0; i < 3; i++) tick();
    check("bp_hold_data", rdata, 8'h20);
    check("bp_hold_level", rlevel, 3);
    check("bp_hold_raddr", raddr, 1);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("bp_step_data", rdata, 8'h21);
    check("bp_step_valid", rvalid, 1);
    check("bp_step_level", rlevel, 2);
    check("bp_step_raddr", raddr, 2);
    tick();
    check("bp_step_hold", rdata, 8'h21);
    rready = 1'b1;
    tick();
    check("bp_drain0", rdata, 8'h22);
    tick();
    check("bp_drain1", rdata, 8'h23);
    check("bp_drain_empty", rempty, 1);
    tick();
    check("bp_drain_valid", rvalid, 0);
    check("bp_drain_rptr", rptr, bin2gray(4'd12));

    // wrap: 16 reads in two bursts of 8
    do_reset();
    for (int i = 0; i < 8; i++) mem[i] = 8'h30 + 8'(i);
    burst(4'd8, 8'h30, 8, 4'd0);
    for (int i = 0; i < 8; i++) mem[i] = 8'h40 + 8'(i);
    burst(4'd0, 8'h40, 8, 4'd8);
    check("wrap_rptr_zero", rptr, 4'b0000);

    // reset mid-stream with a word held and 3 pending
    for (int i = 0; i < 4; i++) mem[i] = 8'h50 + 8'(i);
    rready    = 1'b0;
    wptr_gray = bin2gray(4'd4);
    for (int i = 0; i < 4; i++) tick();
    check("mid_valid", rvalid, 1);
    check("mid_data", rdata, 8'h50);
    check("mid_level", rlevel, 3);
    rrst = 1'b1;
    tick();
    check("mid_rst_valid", rvalid, 0);
    check("mid_rst_empty", rempty, 1);
    check("mid_rst_raddr", raddr, 0);
    check("mid_rst_rptr", rptr, 0);
    check("mid_rst_level", rlevel, 0);
    rrst = 1'b0;
    tick();
    tick();
    check("mid_rel_empty_e2", rempty, 1);
    tick();
    check("mid_rel_empty_e3", rempty, 0);
    check("mid_rel_level_e3", rlevel, 4);
    tick();
    check("mid_rel_valid", rvalid, 1);
    check("mid_rel_data", rdata, 8'h50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
